cpu_controller: RTL and testbench
=================================

# cpu_controller

Single-cycle control unit for the 16-bit RISC datapath. It holds the program counter and decodes the current instruction word into register-file addresses, ALU function, operand/result mux selects and write enables. It sits between instruction memory (drives `IR` from `PC`) and the register file / ALU / data memory. It reads the register-file A-bus value (`D`) for conditional branches and register jumps.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `D` in 16: register-file A-port data, i.e. R[AA], used for branch test and jump target.
- `IR` in 16: current instruction word.
- `PC` out 16: program counter (registered).
- `DA` out 4: destination register address.
- `AA` out 4: A-port register address.
- `BA` out 4: B-port register address.
- `FS` out 3: ALU function select.
- `MB` out 1: ALU B-operand select. 0 = R[BA]; 1 = zero-extended `IR[3:0]`.
- `RW` out 1: register-file write enable.
- `MW` out 1: data-memory write enable.
- `resultSource` out 2: register write-back select. 00 = ALU, 01 = data memory, 10 = zero-extended `IR[7:0]`, 11 = PC+1.

## Operation
- Fields: op = `IR[15:12]`, `DA`=`IR[11:8]`, `AA`=`IR[7:4]`, `BA`=`IR[3:0]`. These address outputs always equal their fields, for every opcode.
- Branch offset: off8 = sign-extend16({`IR[11:8]`,`IR[3:0]`}). Jump offset: joff = sign-extend16(`IR[7:0]`).
- FS encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A, 111 SHR A.
- Default outputs for each opcode, unless the row says otherwise: FS=000, MB=0, RW=0, MW=0, resultSource=00, next PC = PC+1.
- op 0x0–0x7, ALU reg-reg: FS=op[2:0], RW=1.
- op 0x8, ADDI: R[DA] ← R[AA] + `IR[3:0]`. FS=000, MB=1, RW=1.
- op 0x9, LD: R[DA] ← M[R[AA]]. RW=1, resultSource=01.
- op 0xA, ST: M[R[AA]] ← R[BA]. MW=1.
- op 0xB, LDI: R[DA] ← `IR[7:0]`. RW=1, resultSource=10.
- op 0xC, BZ: next PC = PC+off8 if `D`==0, else PC+1.
- op 0xD, BNZ: next PC = PC+off8 if `D`!=0, else PC+1.
- op 0xE, JMP: next PC = `D`.
- op 0xF, JAL: see Configuration.
- Decode outputs are purely combinational from `IR` (and `D` for the next-PC value).
- While `reset`=1: RW=0 and MW=0 are forced; the other decode outputs still follow `IR`.
- PC arithmetic is modulo 2^16. 0xFFFF+1 = 0x0000. Negative offsets wrap the same way.

## Timing
- `reset` asserted: `PC`=0x0000 immediately, without waiting for a clock edge. PC holds 0 while reset is high.
- Each rising `clk` edge with `reset`=0: PC ← next PC. One instruction per cycle; there is no stall or handshake.
- Outputs settle combinationally in the same cycle that `IR`/`D` change. Register and memory writes take effect at the same edge that advances PC.
- Reset deasserted between edges: the first rising edge after deassertion executes the instruction at PC 0.
- Reset asserted mid-instruction: the pending write is suppressed (RW=MW=0) and PC returns to 0 asynchronously.

## Configuration
- `CPU_CONTROLLER_JAL_EN` defined: op 0xF = JAL. RW=1, resultSource=11 (R[DA] ← PC+1), next PC = PC+joff.
- `CPU_CONTROLLER_JAL_EN` undefined: op 0xF = NOP. All write enables are 0 and next PC = PC+1.

## Test plan
- Reset and ADDI: hold reset, IR=0x8006 → PC=0, RW=0. Release reset, IR=0x8006 → DA=0, AA=0, BA=6, FS=000, MB=1, RW=1, MW=0, resultSource=00. PC=1 after the first edge.
- ALU reg-reg, LD, ST: IR=0x4123 → FS=100, RW=1, MB=0. IR=0x9210 → RW=1, resultSource=01. IR=0xA034 → MW=1, RW=0. PC increments by 1 each edge.
- Branches at PC=0x0010: IR=0xCF5E with D=0 → PC=0x0010+0xFFFE=0x000E. Same IR with D=5 → PC=0x0011. IR=0xD0B2 with D=1 → PC=0x0012.
- JMP and wrap: IR=0xE030 with D=0xFFFF → PC=0xFFFF. Next IR=0x8000 → PC=0x0000.
- JAL at PC=0x0020: IR=0xF3FC with macro defined → RW=1, resultSource=11, DA=3, PC=0x001C. With macro undefined → RW=0, PC=0x0021.
- Async reset mid-run: PC=0x0005, raise reset between edges → PC=0x0000 at once, RW=MW=0 until release.

Source files
------------

// File: rtl/cpu_controller.sv
// Single-cycle control unit: holds the PC and decodes IR into datapath controls.
// Optional feature macro: CPU_CONTROLLER_JAL_EN (op 0xF = JAL when defined, NOP otherwise).
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] D,
  input  logic [15:0] IR,
  output logic [15:0] PC,
  output logic [3:0]  DA,
  output logic [3:0]  AA,
  output logic [3:0]  BA,
  output logic [2:0]  FS,
  output logic        MB,
  output logic        RW,
  output logic        MW,
  output logic [1:0]  resultSource
);

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BNZ  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;

  logic [15:0] r_pc;
  logic [3:0]  w_op;
  logic [15:0] w_pcInc;
  logic [15:0] w_off8;
  logic [15:0] w_nextPc;
  logic        w_rw;
  logic        w_mw;
`ifdef CPU_CONTROLLER_JAL_EN
  logic [15:0] w_joff;
`endif

  assign w_op    = IR[15:12];
  assign DA      = IR[11:8];
  assign AA      = IR[7:4];
  assign BA      = IR[3:0];
  assign w_pcInc = r_pc + 16'd1;
  assign w_off8  = {{8{IR[11]}}, IR[11:8], IR[3:0]};
`ifdef CPU_CONTROLLER_JAL_EN
  assign w_joff  = {{8{IR[7]}}, IR[7:0]};
`endif

  always_comb begin
    FS           = 3'b000;
    MB           = 1'b0;
    w_rw         = 1'b0;
    w_mw         = 1'b0;
    resultSource = 2'b00;
    w_nextPc     = w_pcInc;
    if (!w_op[3]) begin
      FS   = w_op[2:0];
      w_rw = 1'b1;
    end else begin
      case (w_op)
        OP_ADDI: begin
          MB   = 1'b1;
          w_rw = 1'b1;
        end
        OP_LD: begin
          w_rw         = 1'b1;
          resultSource = 2'b01;
        end
        OP_ST: w_mw = 1'b1;
        OP_LDI: begin
          w_rw         = 1'b1;
          resultSource = 2'b10;
        end
        OP_BZ:  if (D == 16'h0000) w_nextPc = r_pc + w_off8;
        OP_BNZ: if (D != 16'h0000) w_nextPc = r_pc + w_off8;
        OP_JMP: w_nextPc = D;
        default: begin
`ifdef CPU_CONTROLLER_JAL_EN
          w_rw         = 1'b1;
          resultSource = 2'b11;
          w_nextPc     = r_pc + w_joff;
`else
          w_nextPc     = w_pcInc;
`endif
        end
      endcase
    end
  end

  // Writes are suppressed while reset is held so a half-executed instruction cannot commit.
  assign RW = w_rw & ~reset;
  assign MW = w_mw & ~reset;
  assign PC = r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= 16'h0000;
    else       r_pc <= w_nextPc;
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: driver pushes model expectations, monitor pops and compares.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic [15:0] D;
  logic [15:0] IR;
  logic [15:0] PC;
  logic [3:0]  DA;
  logic [3:0]  AA;
  logic [3:0]  BA;
  logic [2:0]  FS;
  logic        MB;
  logic        RW;
  logic        MW;
  logic [1:0]  resultSource;

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  da;
    logic [3:0]  aa;
    logic [3:0]  ba;
    logic [2:0]  fs;
    logic        mb;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] modelPc = 16'h0000;

  cpu_controller dut (
    .clk(clk), .reset(reset), .D(D), .IR(IR), .PC(PC),
    .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB), .RW(RW), .MW(MW),
    .resultSource(resultSource)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instruction semantics in plain integer arithmetic.
  function automatic void computeExpect(input logic [15:0] ir, input logic [15:0] d,
                                        input logic [15:0] pc, input logic rst,
                                        output exp_t e, output logic [15:0] npc);
    int op;
    int off8;
    int joff;
    int target;
    op     = int'(ir[15:12]);
    off8   = int'({ir[11:8], ir[3:0]});
    joff   = int'(ir[7:0]);
    if (off8 >= 128) off8 = off8 - 256;
    if (joff >= 128) joff = joff - 256;
    target = int'(pc) + 1;
    e.pc = pc;
    e.da = ir[11:8];
    e.aa = ir[7:4];
    e.ba = ir[3:0];
    e.fs = 3'd0;
    e.mb = 1'b0;
    e.rw = 1'b0;
    e.mw = 1'b0;
    e.rs = 2'd0;
    if (op < 8) begin
      e.fs = 3'(op);
      e.rw = 1'b1;
    end else if (op == 8) begin
      e.mb = 1'b1;
      e.rw = 1'b1;
    end else if (op == 9) begin
      e.rw = 1'b1;
      e.rs = 2'd1;
    end else if (op == 10) begin
      e.mw = 1'b1;
    end else if (op == 11) begin
      e.rw = 1'b1;
      e.rs = 2'd2;
    end else if (op == 12) begin
      if (d == 0) target = int'(pc) + off8;
    end else if (op == 13) begin
      if (d != 0) target = int'(pc) + off8;
    end else if (op == 14) begin
      target = int'(d);
    end else begin
`ifdef CPU_CONTROLLER_JAL_EN
      e.rw   = 1'b1;
      e.rs   = 2'd3;
      target = int'(pc) + joff;
`endif
    end
    if (rst) begin
      e.rw = 1'b0;
      e.mw = 1'b0;
    end
    npc = rst ? 16'h0000 : 16'(target & 32'hFFFF);
  endfunction

  task automatic applyStimulus(input logic [15:0] ir, input logic [15:0] d, input logic rst);
    exp_t        e;
    logic [15:0] npc;
    @(posedge clk);
    #1;
    reset = rst;
    IR    = ir;
    D     = d;
    if (rst) modelPc = 16'h0000;
    computeExpect(ir, d, modelPc, rst, e, npc);
    expQ.push_back(e);
    modelPc = npc;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Monitor: the controller presents a full decode every cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("PC", PC, e.pc);
        checkOutput("DA", 16'(DA), 16'(e.da));
        checkOutput("AA", 16'(AA), 16'(e.aa));
        checkOutput("BA", 16'(BA), 16'(e.ba));
        checkOutput("FS", 16'(FS), 16'(e.fs));
        checkOutput("MB", 16'(MB), 16'(e.mb));
        checkOutput("RW", 16'(RW), 16'(e.rw));
        checkOutput("MW", 16'(MW), 16'(e.mw));
        checkOutput("resultSource", 16'(resultSource), 16'(e.rs));
      end
    end
  end

  typedef struct {
    logic [15:0] ir;
    logic [15:0] d;
    logic        rst;
  } stim_t;

  stim_t directed[$];

  initial begin
    reset = 1'b1;
    IR    = 16'h8006;
    D     = 16'h0000;
    directed = '{
      '{16'h8006, 16'h0000, 1'b1}, '{16'h8006, 16'h0000, 1'b1},
      '{16'h8006, 16'h0000, 1'b0}, '{16'h4123, 16'h0000, 1'b0},
      '{16'h9210, 16'h0000, 1'b0}, '{16'hA034, 16'h0000, 1'b0},
      '{16'hE030, 16'h0010, 1'b0}, '{16'hCF5E, 16'h0000, 1'b0},
      '{16'hE030, 16'h0010, 1'b0}, '{16'hCF5E, 16'h0005, 1'b0},
      '{16'hE030, 16'h0010, 1'b0}, '{16'hD0B2, 16'h0001, 1'b0},
      '{16'hE030, 16'hFFFF, 1'b0}, '{16'h8000, 16'h0000, 1'b0},
      '{16'h8000, 16'h0000, 1'b0}, '{16'hE030, 16'h0020, 1'b0},
      '{16'hF3FC, 16'h0000, 1'b0}, '{16'hE030, 16'h0005, 1'b0},
      '{16'hA034, 16'h0000, 1'b0}, '{16'h4123, 16'h0000, 1'b1},
      '{16'hA034, 16'h0000, 1'b1}, '{16'h8006, 16'h0000, 1'b0},
      '{16'h8006, 16'h0000, 1'b0}
    };
    foreach (directed[i]) applyStimulus(directed[i].ir, directed[i].d, directed[i].rst);
    for (int n = 0; n < 400; n++) begin
      logic [15:0] rIr;
      logic [15:0] rD;
      logic        rRst;
      rIr  = 16'($urandom);
      rD   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      rRst = ($urandom_range(0, 29) == 0);
      applyStimulus(rIr, rD, rRst);
    end
    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0 pending expectations", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
